// File: rtl/chrom_serial_loader.sv
// Serial chromosome loader: shifts a chromosome into a shadow register over a valid/ready
// link, range-checks the output selectors, then commits tables and selectors atomically.
module chrom_serial_loader #(
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int OUT   = 2,
  parameter int SEL_W = $clog2(ROW * COL)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic                           i_ser_data,
  input  logic                           i_ser_valid,
  output logic                           o_ser_ready,
  output logic [ROW-1:0][COL-1:0][15:0]  o_saidas_LE,
  output logic [OUT-1:0][SEL_W-1:0]      o_out_chrom,
  output logic                           o_chrom_valid,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err
);

  localparam int NCELL = ROW * COL;
  localparam int NBITS = NCELL * 16 + OUT * SEL_W;
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam int IDX_W = (OUT > 1) ? $clog2(OUT) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(NBITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(OUT - 1);
  localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(NCELL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_COMMIT,
    S_REJECT
  } state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [NBITS-1:0]               r_shadow;
  logic [CNT_W-1:0]               r_cnt;
  logic [IDX_W-1:0]               r_idx;
  logic                           r_bad;
  logic                           w_accept;
  logic                           w_sel_bad;
  logic [SEL_W-1:0]               w_sel;
  logic [ROW-1:0][COL-1:0][15:0]  w_tables;
  logic [OUT-1:0][SEL_W-1:0]      w_sels;

  // First bit received ends up at the shadow MSB, so cell (0,0) bit 15 is on top
  // and selector OUT-1 occupies the lowest SEL_W bits.
  always_comb begin
    w_tables = '0;
    w_sels   = '0;
    for (int i = 0; i < ROW; i++) begin
      for (int j = 0; j < COL; j++) begin
        w_tables[i][j] = r_shadow[NBITS - 16 - 16 * (i * COL + j) +: 16];
      end
    end
    for (int k = 0; k < OUT; k++) begin
      w_sels[k] = r_shadow[(OUT - 1 - k) * SEL_W +: SEL_W];
    end
  end

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < OUT; k++) begin
      if (r_idx == IDX_W'(k)) w_sel = w_sels[k];
    end
    w_sel_bad = ({1'b0, w_sel} >= SEL_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    o_ser_ready = 1'b0;
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) w_next = S_LOAD;
      end
      S_LOAD: begin
        o_ser_ready = 1'b1;
        if (i_abort)                              w_next = S_IDLE;
        else if (i_ser_valid && r_cnt == LAST_BIT) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (i_abort)                w_next = S_IDLE;
        else if (r_idx == LAST_IDX) w_next = (r_bad || w_sel_bad) ? S_REJECT : S_COMMIT;
      end
      S_COMMIT: w_next = S_IDLE;
      S_REJECT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_accept = i_ser_valid && o_ser_ready && !i_abort;

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow is an ordinary register bank, not a RAM, so it is reset
      // along with the rest; a mid-load reset leaves no stale chromosome behind.
      r_shadow      <= '0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_bad         <= 1'b0;
      o_saidas_LE   <= '0;
      o_out_chrom   <= '0;
      o_chrom_valid <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_bad <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_shadow <= {r_shadow[NBITS-2:0], i_ser_data};
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          if (!i_abort) begin
            r_bad <= r_bad | w_sel_bad;
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_COMMIT: begin
          o_saidas_LE   <= w_tables;
          o_out_chrom   <= w_sels;
          o_chrom_valid <= 1'b1;
          o_done        <= 1'b1;
        end
        S_REJECT: begin
          o_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chrom_serial_loader.sv
// Bench for chrom_serial_loader (ROW=2, COL=3, OUT=2, SEL_W=3): a reference model of the
// committed configuration, directed loads, randomized loads and a vector table for control.
module tb_chrom_serial_loader;

  localparam int ROW   = 2;
  localparam int COL   = 3;
  localparam int OUT   = 2;
  localparam int SEL_W = 3;
  localparam int NCELL = ROW * COL;
  localparam int NBITS = NCELL * 16 + OUT * SEL_W;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic ser_data;
  logic ser_valid;
  logic ser_ready;
  logic [ROW-1:0][COL-1:0][15:0] saidas_le;
  logic [OUT-1:0][SEL_W-1:0]     out_chrom;
  logic chrom_valid;
  logic busy;
  logic done;
  logic err;

  chrom_serial_loader #(.ROW(ROW), .COL(COL), .OUT(OUT), .SEL_W(SEL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_abort      (abort),
    .i_ser_data   (ser_data),
    .i_ser_valid  (ser_valid),
    .o_ser_ready  (ser_ready),
    .o_saidas_LE  (saidas_le),
    .o_out_chrom  (out_chrom),
    .o_chrom_valid(chrom_valid),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the configuration the grid should currently see.
  logic [15:0]      exp_tab[NCELL];
  logic [SEL_W-1:0] exp_sel[OUT];
  logic             exp_cv;

  typedef struct {
    logic start;
    logic abort;
    logic valid;
    logic exp_busy;
    logic exp_ready;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCELL; c++) exp_tab[c] = '0;
    for (int k = 0; k < OUT; k++) exp_sel[k] = '0;
    exp_cv = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    for (int c = 0; c < NCELL; c++)
      check($sformatf("%s_table[%0d][%0d]", tag, c / COL, c % COL),
            64'(saidas_le[c / COL][c % COL]), 64'(exp_tab[c]));
    for (int k = 0; k < OUT; k++)
      check($sformatf("%s_sel[%0d]", tag, k), 64'(out_chrom[k]), 64'(exp_sel[k]));
    check({tag, "_chrom_valid"}, 64'(chrom_valid), 64'(exp_cv));
  endtask

  // Cycle numbering: the cycle that presents start is 0. cut_at stops the stream after
  // that many accepted bits, by abort (cut_kind 1) or reset (cut_kind 2).
  task automatic run_load(input logic [15:0] tabs[NCELL], input logic [SEL_W-1:0] sels[OUT],
                          input int mode, input int cut_at, input int cut_kind,
                          output int n_done, output int n_err, output int fin_at,
                          output int last_acc);
    bit q[$];
    int cyc;
    int popped;
    bit rdy;
    bit v;
    bit hs;
    bit timed_out;
    for (int c = 0; c < NCELL; c++)
      for (int b = 15; b >= 0; b--) q.push_back(tabs[c][b]);
    for (int k = 0; k < OUT; k++)
      for (int b = SEL_W - 1; b >= 0; b--) q.push_back(sels[k][b]);
    n_done = 0; n_err = 0; fin_at = -1; last_acc = -1; popped = 0; timed_out = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (q.size() > 0) begin
      if (popped == cut_at) begin
        ser_valid = 1'b1;
        if (cut_kind == 1) abort = 1'b1;
        else rst = 1'b1;
        tick();
        abort = 1'b0; rst = 1'b0; ser_valid = 1'b0;
        check(cut_kind == 1 ? "abort_busy" : "reset_busy", 64'(busy), 64'd0);
        check(cut_kind == 1 ? "abort_ready" : "reset_ready", 64'(ser_ready), 64'd0);
        break;
      end
      rdy = ser_ready;
      v = (mode == 0) ? 1'b1 : ((cyc % 2 == 1) && ($urandom_range(0, 3) != 0));
      ser_valid = v;
      ser_data  = q[0];
      hs = v && rdy;
      tick();
      if (hs) begin
        void'(q.pop_front());
        popped++;
        last_acc = cyc;
      end
      cyc++;
      if (done) n_done++;
      if (err) n_err++;
      if (cyc > 4 * NBITS + 20) begin
        timed_out = 1'b1;
        break;
      end
    end
    check("stream_bound", 64'(timed_out), 64'd0);
    ser_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ser_valid = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
      if (done) n_done++;
      if (err) n_err++;
      if ((done || err) && fin_at < 0) fin_at = cyc;
    end
    ser_valid = 1'b0;
  endtask

  // Full load whose outcome follows from the selector range rule.
  task automatic load_expect(input logic [15:0] tabs[NCELL], input logic [SEL_W-1:0] sels[OUT],
                             input int mode, input string tag);
    int nd, ne, fin, last;
    bit good;
    good = 1'b1;
    for (int k = 0; k < OUT; k++) if (int'(sels[k]) >= NCELL) good = 1'b0;
    run_load(tabs, sels, mode, -1, 0, nd, ne, fin, last);
    check({tag, "_done_count"}, 64'(nd), good ? 64'd1 : 64'd0);
    check({tag, "_err_count"}, 64'(ne), good ? 64'd0 : 64'd1);
    check({tag, "_finish_after_last_bit"}, 64'(fin - last), 64'(OUT + 2));
    if (mode == 0) check({tag, "_start_to_finish"}, 64'(fin), 64'(NBITS + OUT + 2));
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    if (good) begin
      for (int c = 0; c < NCELL; c++) exp_tab[c] = tabs[c];
      for (int k = 0; k < OUT; k++) exp_sel[k] = sels[k];
      exp_cv = 1'b1;
    end
    check_outputs(tag);
  endtask

  logic [15:0]      tabs[NCELL];
  logic [SEL_W-1:0] sels[OUT];
  logic [15:0]      nom_tabs[NCELL];
  logic [SEL_W-1:0] nom_sels[OUT];
  int nd, ne, fin, last;

  initial begin
    vecs[0] = '{start: 1'b0, abort: 1'b0, valid: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};
    vecs[1] = '{start: 1'b1, abort: 1'b1, valid: 1'b0, exp_busy: 1'b0, exp_ready: 1'b0};
    vecs[2] = '{start: 1'b0, abort: 1'b1, valid: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};
    vecs[3] = '{start: 1'b1, abort: 1'b0, valid: 1'b0, exp_busy: 1'b1, exp_ready: 1'b1};
    vecs[4] = '{start: 1'b1, abort: 1'b0, valid: 1'b1, exp_busy: 1'b1, exp_ready: 1'b1};
    vecs[5] = '{start: 1'b0, abort: 1'b1, valid: 1'b0, exp_busy: 1'b0, exp_ready: 1'b0};
    vecs[6] = '{start: 1'b0, abort: 1'b0, valid: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};
    vecs[7] = '{start: 1'b1, abort: 1'b0, valid: 1'b1, exp_busy: 1'b1, exp_ready: 1'b1};
    vecs[8] = '{start: 1'b0, abort: 1'b1, valid: 1'b1, exp_busy: 1'b0, exp_ready: 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; ser_data = 1'b0; ser_valid = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      ser_valid = i[0];
      ser_data  = 1'b1;
      tick();
      check($sformatf("idle_busy_%0d", i), 64'(busy), 64'd0);
      check($sformatf("idle_ready_%0d", i), 64'(ser_ready), 64'd0);
      check($sformatf("idle_done_err_%0d", i), 64'({done, err}), 64'd0);
    end
    ser_valid = 1'b0;
    check_outputs("reset");

    for (int c = 0; c < NCELL; c++) nom_tabs[c] = 16'(c + 1);
    nom_sels[0] = 3'd5;
    nom_sels[1] = 3'd0;
    load_expect(nom_tabs, nom_sels, 0, "nominal");
    check("nominal_table_1_2", 64'(saidas_le[1][2]), 64'h0006);
    check("nominal_table_0_0", 64'(saidas_le[0][0]), 64'h0001);

    for (int c = 0; c < NCELL; c++) tabs[c] = 16'hA5A5;
    sels[0] = 3'd7;
    sels[1] = 3'd1;
    load_expect(tabs, sels, 0, "reject");

    for (int c = 0; c < NCELL; c++) tabs[c] = 16'h1234;
    sels[0] = 3'd3;
    sels[1] = 3'd3;
    load_expect(tabs, sels, 1, "throttle_pre");
    load_expect(nom_tabs, nom_sels, 1, "throttled");

    for (int c = 0; c < NCELL; c++) tabs[c] = 16'(c * 16'h1111);
    sels[0] = 3'd2;
    sels[1] = 3'd4;
    run_load(tabs, sels, 0, 50, 1, nd, ne, fin, last);
    check("abort_done_count", 64'(nd), 64'd0);
    check("abort_err_count", 64'(ne), 64'd0);
    check_outputs("abort_hold");
    for (int c = 0; c < NCELL; c++) tabs[c] = 16'hFFFF;
    sels[0] = 3'd1;
    sels[1] = 3'd2;
    load_expect(tabs, sels, 0, "after_abort");

    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < NCELL; c++) tabs[c] = 16'($urandom());
      for (int k = 0; k < OUT; k++) sels[k] = 3'($urandom_range(0, 7));
      load_expect(tabs, sels, int'($urandom_range(0, 1)), $sformatf("random%0d", it));
    end

    for (int c = 0; c < NCELL; c++) tabs[c] = 16'hBEEF;
    sels[0] = 3'd0;
    sels[1] = 3'd5;
    run_load(tabs, sels, 0, 80, 2, nd, ne, fin, last);
    model_reset();
    check("midreset_done_count", 64'(nd), 64'd0);
    check("midreset_err_count", 64'(ne), 64'd0);
    check_outputs("midreset");

    for (int i = 0; i < 9; i++) begin
      start     = vecs[i].start;
      abort     = vecs[i].abort;
      ser_valid = vecs[i].valid;
      ser_data  = 1'b1;
      tick();
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      check($sformatf("vec%0d_ready", i), 64'(ser_ready), 64'(vecs[i].exp_ready));
    end
    start = 1'b0; abort = 1'b0; ser_valid = 1'b0;
    check_outputs("vec_hold");

    load_expect(nom_tabs, nom_sels, 0, "final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
